// File: rtl/pwm_multich.sv
// Multi-channel PWM: a shared counter, double-buffered period/duty registers, edge-aligned output.
// Define PWM_CENTER_EN to add center-aligned (up/down) mode, selected by the mode input.
module pwm_multich #(
  parameter int N = 4,
  parameter int R = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         mode,
  input  logic [R-1:0] period_in,
  input  logic [N*R-1:0] duty_in,
  input  logic         load,
  output logic         load_pending,
  output logic         period_tick,
  output logic [N-1:0] pwm_out
);

  logic [R-1:0]   r_cnt;
  logic [R-1:0]   r_per;
  logic [R-1:0]   r_sh_per;
  logic [N*R-1:0] r_duty;
  logic [N*R-1:0] r_sh_duty;
  logic           w_bnd;
  logic           w_xfer;
  logic [R-1:0]   w_cnt_nxt;
  logic [N-1:0]   w_hit;

`ifdef PWM_CENTER_EN
  logic r_dir;
  logic r_mode;
  logic w_dir_nxt;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
`endif

  always_comb begin
    w_bnd     = 1'b0;
    w_cnt_nxt = r_cnt + R'(1);
`ifdef PWM_CENTER_EN
    w_dir_nxt = r_dir;
    if (r_mode) begin
      if (!r_dir) begin
        if (r_cnt >= r_per) begin
          // Period 0/1 has no down leg; wrap straight to 0.
          if (r_per <= R'(1)) begin
            w_bnd     = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_dir_nxt = 1'b1;
            w_cnt_nxt = r_cnt - R'(1);
          end
        end
      end else begin
        w_cnt_nxt = r_cnt - R'(1);
        if (r_cnt <= R'(1)) begin
          w_bnd     = 1'b1;
          w_cnt_nxt = '0;
          w_dir_nxt = 1'b0;
        end
      end
    end else
`endif
    begin
      if (r_cnt >= r_per) begin
        w_bnd     = 1'b1;
        w_cnt_nxt = '0;
      end
    end
  end

  // Disabled: drain pending shadow every cycle; running: only at a boundary.
  assign w_xfer = load_pending & (~enable | w_bnd);

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N; i++) begin
      w_hit[i] = r_cnt < r_duty[i*R +: R];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_per        <= '1;
      r_sh_per     <= '1;
      r_duty       <= '0;
      r_sh_duty    <= '0;
      load_pending <= 1'b0;
      period_tick  <= 1'b0;
      pwm_out      <= '0;
`ifdef PWM_CENTER_EN
      r_dir        <= 1'b0;
      r_mode       <= 1'b0;
`endif
    end else begin
      if (load) begin
        r_sh_per     <= period_in;
        r_sh_duty    <= duty_in;
        load_pending <= 1'b1;
      end else if (w_xfer) begin
        load_pending <= 1'b0;
      end
      if (w_xfer) begin
        r_per  <= r_sh_per;
        r_duty <= r_sh_duty;
      end
      if (enable) begin
        r_cnt       <= w_cnt_nxt;
        period_tick <= w_bnd;
        pwm_out     <= w_hit;
`ifdef PWM_CENTER_EN
        r_dir       <= w_dir_nxt;
        if (w_bnd) r_mode <= mode;
`endif
      end else begin
        r_cnt       <= '0;
        period_tick <= 1'b0;
        pwm_out     <= '0;
`ifdef PWM_CENTER_EN
        r_dir       <= 1'b0;
        r_mode      <= mode;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwm_multich.sv
// Randomized bench for pwm_multich against a phase-index reference model.
// Directed windows cover fixed duty ratios, reload, period 0 and reset.
module tb_pwm_multich;
  localparam int N = 4;
  localparam int R = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           mode;
  logic           load;
  logic [R-1:0]   period_in;
  logic [N*R-1:0] duty_in;
  logic           load_pending;
  logic           period_tick;
  logic [N-1:0]   pwm_out;

  pwm_multich #(.N(N), .R(R)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mode(mode), .period_in(period_in),
    .duty_in(duty_in), .load(load),
    .load_pending(load_pending),
    .period_tick(period_tick),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, act, exp);
    end
  endtask

  // Reference model: position in period as a phase index.
  int m_p, m_per, m_mode, m_pend, sh_per;
  int m_duty[N];
  int sh_duty[N];
  logic [N-1:0] e_pwm;
  logic e_tick, e_pend;

  function automatic int plen(int per, int md);
    if (per == 0) return 1;
    if (md != 0) return 2 * per;
    return per + 1;
  endfunction

  function automatic int cval(int p, int per, int md);
    if (md == 0) return p;
    if (p <= per) return p;
    return 2 * per - p;
  endfunction

  task automatic model_step();
    int len, c;
    bit bnd, xfer;
    if (reset) begin
      m_p = 0; m_per = 255; sh_per = 255;
      m_mode = 0; m_pend = 0;
      for (int i = 0; i < N; i++) begin
        m_duty[i] = 0; sh_duty[i] = 0;
      end
      e_pwm = '0; e_tick = 0; e_pend = 0;
      return;
    end
    len = plen(m_per, m_mode);
    c = cval(m_p, m_per, m_mode);
    bnd = enable && (m_p == len - 1);
    for (int i = 0; i < N; i++)
      e_pwm[i] = enable && (c < m_duty[i]);
    e_tick = bnd;
    xfer = (m_pend != 0) && (!enable || bnd);
    m_p = (!enable || bnd) ? 0 : m_p + 1;
    if (xfer) begin
      m_per = sh_per;
      for (int i = 0; i < N; i++) m_duty[i] = sh_duty[i];
    end
`ifdef PWM_CENTER_EN
    if (!enable || bnd) m_mode = int'(mode);
`else
    m_mode = 0;
`endif
    if (load) begin
      sh_per = int'(period_in);
      for (int i = 0; i < N; i++)
        sh_duty[i] = int'(duty_in[i*R +: R]);
      m_pend = 1;
    end else if (xfer) begin
      m_pend = 0;
    end
    e_pend = m_pend[0];
  endtask

  task automatic run1();
    model_step();
    @(negedge clk);
    check("pwm", 32'(pwm_out), 32'(e_pwm));
    check("tick", 32'(period_tick), 32'(e_tick));
    check("pend", 32'(load_pending), 32'(e_pend));
  endtask

  task automatic do_load(input int per, input logic [N*R-1:0] d);
    period_in = R'(per);
    duty_in = d;
    load = 1'b1;
    run1();
    load = 1'b0;
  endtask

  task automatic window(input int n, output int h0, output int h1,
                        output int h2, output int tk);
    h0 = 0; h1 = 0; h2 = 0; tk = 0;
    for (int k = 0; k < n; k++) begin
      run1();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      tk += int'(period_tick);
    end
  endtask

  initial begin
    int h0, h1, h2, tk;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; load = 1'b0;
    period_in = '0; duty_in = '0;
    @(negedge clk);
    run1();
    run1();
    reset = 1'b0;
    run1();

    // per 9, duties 0,3,10,255; disabled load transfers at once
    do_load(9, {8'd255, 8'd10, 8'd3, 8'd0});
    run1();
    enable = 1'b1;
    for (int k = 0; k < 12; k++) run1();
    window(20, h0, h1, h2, tk);
    check("r28_ch0", 32'(h0), 32'd0);
    check("r28_ch1", 32'(h1), 32'd6);
    check("r28_ch2", 32'(h2), 32'd20);
    check("r28_tick", 32'(tk), 32'd2);

    // mid-period reload to per 4 duty 2, two loads, load at boundary
    for (int k = 0; k < 4; k++) run1();
    do_load(4, {4{8'd5}});
    run1();
    do_load(4, {4{8'd2}});
    for (int k = 0; k < 20; k++) run1();
    window(20, h0, h1, h2, tk);
    check("r29_ch0", 32'(h0), 32'd8);
    check("r29_tick", 32'(tk), 32'd4);
    while (!(e_tick && pwm_out == '0)) run1();
    for (int k = 0; k < 3; k++) run1();
    do_load(4, {4{8'd3}});
    for (int k = 0; k < 12; k++) run1();

    // period 0
    do_load(0, {8'd0, 8'd1, 8'd0, 8'd1});
    for (int k = 0; k < 12; k++) run1();
    window(10, h0, h1, h2, tk);
    check("r32_ch0", 32'(h0), 32'd10);
    check("r32_ch1", 32'(h1), 32'd0);
    check("r32_tick", 32'(tk), 32'd10);

`ifdef PWM_CENTER_EN
    mode = 1'b1;
    do_load(4, {4{8'd2}});
    for (int k = 0; k < 20; k++) run1();
    window(16, h0, h1, h2, tk);
    check("r31_ch0", 32'(h0), 32'd6);
    check("r31_tick", 32'(tk), 32'd2);
    mode = 1'b0;
`endif

    // reset mid-period with a pending load
    do_load(9, {4{8'd4}});
    run1();
    reset = 1'b1;
    run1();
    check("r33_pwm", 32'(pwm_out), 32'd0);
    check("r33_pend", 32'(load_pending), 32'd0);
    reset = 1'b0;
    enable = 1'b0;
    do_load(3, {4{8'd1}});
    run1();
    check("r33_xfer", 32'(load_pending), 32'd0);

    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom % 400) == 0;
      enable = ($urandom % 16) != 0;
      mode = 1'($urandom % 2);
      load = ($urandom % 10) == 0;
      period_in = R'($urandom % 13);
      for (int i = 0; i < N; i++)
        duty_in[i*R +: R] = R'($urandom % 16);
      run1();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multich.md
PWM_MULTICH -- requirements
Module: pwm_multich

Interface
REQ-001 SHALL provide parameter N, default 4, number of PWM channels (1..16).
REQ-002 SHALL provide parameter R, default 9, counter/duty/period width in bits (2..16).
REQ-003 SHALL provide: clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL provide: reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide: enable  input  1  run control; low = counter held, outputs low.
REQ-006 SHALL provide: mode  input  1  0 = edge-aligned, 1 = center-aligned (see REQ-027).
REQ-007 SHALL provide: period_in  input  R  period value for next shadow load.
REQ-008 SHALL provide: duty_in  input  N*R  duty values; channel i in bits [i*R +: R].
REQ-009 SHALL provide: load  input  1  single-cycle strobe capturing period_in/duty_in into shadow.
REQ-010 SHALL provide: load_pending  output  1  high while shadow holds values not yet active.
REQ-011 SHALL provide: period_tick  output  1  one-cycle pulse per period boundary.
REQ-012 SHALL provide: pwm_out  output  N  registered PWM outputs, bit i = channel i.

Function
REQ-013 SHALL keep one shared R-bit counter cnt and active registers per_act, duty_act[N].
REQ-014 Edge mode: cnt SHALL count 0,1..per_act, then 0; period = per_act+1 cycles; boundary = cycle cnt==per_act.
REQ-015 Center mode: cnt SHALL count up 0..per_act then down per_act-1..1, then 0; period = 2*per_act cycles; boundary = cycle cnt==1 while counting down (or cnt==0 when per_act==0).
REQ-016 per_act==0 SHALL hold cnt at 0 with every enabled cycle a boundary.
REQ-017 pwm_out[i] SHALL equal, one cycle later, (cnt < duty_act[i]) evaluated this cycle; duty 0 = always low, duty > per_act = always high.
REQ-018 On load, shadow SHALL capture period_in/duty_in and load_pending SHALL go high next cycle.
REQ-019 load while load_pending SHALL overwrite shadow (last wins); load_pending stays high.
REQ-020 At a boundary with load_pending high, active registers SHALL take shadow values, taking effect from the following cnt==0 cycle; load_pending clears next cycle.
REQ-021 load coincident with a boundary: transfer SHALL use pre-existing shadow (if pending); the new values stay pending until next boundary.
REQ-022 period_tick SHALL be high exactly the cycle after each boundary.
REQ-023 enable low: cnt SHALL be 0, direction up, pwm_out all 0, period_tick 0; pending shadow SHALL transfer to active each cycle.
REQ-024 enable rising: cnt SHALL start at 0 the first enabled cycle; pwm_out valid from the next cycle.
REQ-025 mode change SHALL only take effect at a boundary (mode sampled with shadow transfer, or immediately while enable low).

Reset
REQ-026 reset SHALL set cnt=0, direction up, per_act=shadow period={R{1}}, duty_act=shadow duties=0, active mode edge, load_pending=0, period_tick=0, pwm_out=0; reset overrides load and enable in the same cycle, including mid-period.

Configuration
REQ-027 Macro PWM_CENTER_EN: defined -> center-aligned mode per REQ-015 selectable via mode; undefined -> mode input ignored, edge-aligned only, no up/down logic synthesized.

Verification
REQ-028 R=8,N=4, per 9, duties 0,3,10,255, edge -> period 10 cycles; ch0 always low, ch1 high 3 of 10, ch2 and ch3 always high; period_tick every 10 cycles.
REQ-029 Running per 9 duty 3; load per 4 duty 2 mid-period -> old waveform completes, new 5-cycle period with 2 high begins after boundary; load_pending high until boundary+1.
REQ-030 Two loads (duty 5 then duty 7) in one period -> only duty 7 applied; load at boundary cycle -> applied one period later.
REQ-031 PWM_CENTER_EN, mode 1, per 4, duty 2 -> 8-cycle period, cnt 0,1,2,3,4,3,2,1, output high 3 of 8 cycles, symmetric.
REQ-032 per 0, duty 1 -> output constantly high, period_tick high every cycle; duty 0 -> constantly low.
REQ-033 reset asserted mid-period with load_pending high -> next cycle all outputs 0, load_pending 0, cnt 0; enable low -> outputs 0, shadow transferred immediately.
